fp16_calc_sequencer: RTL

- Top-level controller for the keypad-driven FP16 calculator.
- Collects two 4-digit hex operands from decoded key events, launches the half-precision multiplier with a start/done handshake and enforces a timeout.
- Drives the value and blanking mask for the 4-digit seven-segment display.
- Replaces the manual per-digit switch sequencing with one FSM, and sits between the keypad scanner, the fp16 multiplier and the hex-to-7seg decoder.

---
 rtl/fp16_calc_pkg.sv | 28 ++
 rtl/fp16_calc_sequencer_if.sv | 30 +++
 rtl/hex_entry_buf.sv | 39 +++
 rtl/fp16_calc_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fp16_calc_pkg.sv
// Shared types, widths and helpers for the keypad-driven FP16 calculator.
package fp16_calc_pkg;

  localparam int DIGITS    = 4;
  localparam int NIBBLE_W  = 4;
  localparam int OPERAND_W = 16;

  localparam logic [OPERAND_W-1:0] DEFAULT_ERR_PATTERN = 16'hEEEE;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  // Digits at or above the entered count stay dark, so a count of 0 blanks all.
  function automatic logic [DIGITS-1:0] count_to_blank(input logic [2:0] count);
    logic [DIGITS-1:0] mask;
    for (int n = 0; n < DIGITS; n++) begin
      mask[n] = (n >= int'(count));
    end
    return mask;
  endfunction

endpackage

// File: rtl/fp16_calc_sequencer_if.sv
// Keypad, multiplier and display signals of the calculator sequencer.
interface fp16_calc_sequencer_if;
  import fp16_calc_pkg::*;

  logic                 key_valid;
  logic [NIBBLE_W-1:0]  key_code;
  logic                 btn_enter;
  logic                 btn_clear;
  logic                 mult_start;
  logic [OPERAND_W-1:0] mult_op_a;
  logic [OPERAND_W-1:0] mult_op_b;
  logic                 mult_done;
  logic [OPERAND_W-1:0] mult_result;
  logic [OPERAND_W-1:0] disp_value;
  logic [DIGITS-1:0]    disp_blank;
  logic                 busy;
  logic                 err;
  logic [2:0]           state_dbg;

  modport master (
    output key_valid, key_code, btn_enter, btn_clear, mult_done, mult_result,
    input  mult_start, mult_op_a, mult_op_b, disp_value, disp_blank, busy, err, state_dbg
  );

  modport slave (
    input  key_valid, key_code, btn_enter, btn_clear, mult_done, mult_result,
    output mult_start, mult_op_a, mult_op_b, disp_value, disp_blank, busy, err, state_dbg
  );

endinterface

// File: rtl/hex_entry_buf.sv
// Four-digit hex entry shift register with a saturating digit count.
module hex_entry_buf
  import fp16_calc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_shift_en,
  input  logic                 i_clear,
  input  logic [NIBBLE_W-1:0]  i_digit,
  output logic [OPERAND_W-1:0] o_buffer,
  output logic [2:0]           o_count
);

  logic [OPERAND_W-1:0] r_buffer;
  logic [2:0]           r_count;

  // Clear together with shift loads the digit as the first of a fresh entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buffer <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      if (i_shift_en) begin
        r_buffer <= {{(OPERAND_W-NIBBLE_W){1'b0}}, i_digit};
        r_count  <= 3'd1;
      end else begin
        r_buffer <= '0;
        r_count  <= '0;
      end
    end else if (i_shift_en && (r_count < 3'(DIGITS))) begin
      r_buffer <= {r_buffer[OPERAND_W-NIBBLE_W-1:0], i_digit};
      r_count  <= r_count + 3'd1;
    end
  end

  assign o_buffer = r_buffer;
  assign o_count  = r_count;

endmodule

// File: rtl/fp16_calc_sequencer.sv
// Calculator controller: operand entry, multiplier launch with timeout, display drive.
module fp16_calc_sequencer
  import fp16_calc_pkg::*;
#(
  parameter int unsigned          TIMEOUT_CYCLES = 1024,
  parameter logic [OPERAND_W-1:0] ERR_PATTERN    = DEFAULT_ERR_PATTERN
) (
  input  logic                 clk,
  input  logic                 rst,
  fp16_calc_sequencer_if.slave bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [OPERAND_W-1:0] r_op_a;
  logic [OPERAND_W-1:0] r_op_b;
  logic [OPERAND_W-1:0] r_result;
  logic [TMR_W-1:0]     r_timer;

  logic [OPERAND_W-1:0] w_buffer;
  logic [2:0]           w_count;
  logic                 w_enter;
  logic                 w_key;
  logic                 w_clear_all;
  logic                 w_buf_clear;
  logic                 w_buf_shift;
  logic                 w_load_a;
  logic                 w_load_b;
  logic                 w_load_res;

  assign w_enter = bus.btn_enter & ~bus.btn_clear;
  assign w_key   = bus.key_valid & ~bus.btn_clear & ~bus.btn_enter;

  hex_entry_buf u_entry (
    .clk        (clk),
    .rst        (rst),
    .i_shift_en (w_buf_shift),
    .i_clear    (w_buf_clear),
    .i_digit    (bus.key_code),
    .o_buffer   (w_buffer),
    .o_count    (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_ENTER_A;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_timer  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_clear_all) begin
        r_op_a   <= '0;
        r_op_b   <= '0;
        r_result <= '0;
        r_timer  <= '0;
      end else begin
        if (w_load_a)   r_op_a   <= w_buffer;
        if (w_load_b)   r_op_b   <= w_buffer;
        if (w_load_res) r_result <= bus.mult_result;
        if (r_state == ST_LAUNCH) begin
          r_timer <= '0;
        end else if ((r_state == ST_WAIT) && (r_timer != TMR_LAST)) begin
          r_timer <= r_timer + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_clear_all  = 1'b0;
    w_buf_clear  = 1'b0;
    w_buf_shift  = 1'b0;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_res   = 1'b0;
    if (bus.btn_clear) begin
      w_next_state = ST_ENTER_A;
      w_clear_all  = 1'b1;
      w_buf_clear  = 1'b1;
    end else begin
      case (r_state)
        ST_ENTER_A: begin
          if (w_enter) begin
            if (w_count != 3'd0) begin
              w_load_a     = 1'b1;
              w_buf_clear  = 1'b1;
              w_next_state = ST_ENTER_B;
            end
          end else if (w_key) begin
            w_buf_shift = 1'b1;
          end
        end
        ST_ENTER_B: begin
          if (w_enter) begin
            if (w_count != 3'd0) begin
              w_load_b     = 1'b1;
              w_buf_clear  = 1'b1;
              w_next_state = ST_LAUNCH;
            end
          end else if (w_key) begin
            w_buf_shift = 1'b1;
          end
        end
        ST_LAUNCH: w_next_state = ST_WAIT;
        // A done pulse on the final count still wins over the timeout.
        ST_WAIT: begin
          if (bus.mult_done) begin
            w_load_res   = 1'b1;
            w_next_state = ST_SHOW;
          end else if (r_timer == TMR_LAST) begin
            w_next_state = ST_ERR;
          end
        end
        ST_SHOW: begin
          if (w_enter) begin
            w_next_state = ST_LAUNCH;
          end else if (w_key) begin
            w_buf_clear  = 1'b1;
            w_buf_shift  = 1'b1;
            w_next_state = ST_ENTER_A;
          end
        end
        ST_ERR:  w_next_state = ST_ERR;
        default: w_next_state = ST_ENTER_A;
      endcase
    end
  end

  always_comb begin
    bus.disp_value = '0;
    bus.disp_blank = '1;
    case (r_state)
      ST_ENTER_A, ST_ENTER_B: begin
        bus.disp_value = w_buffer;
        bus.disp_blank = count_to_blank(w_count);
      end
      ST_LAUNCH, ST_WAIT: begin
        bus.disp_value = r_op_b;
        bus.disp_blank = '1;
      end
      ST_SHOW: begin
        bus.disp_value = r_result;
        bus.disp_blank = '0;
      end
      ST_ERR: begin
        bus.disp_value = ERR_PATTERN;
        bus.disp_blank = '0;
      end
      default: begin
        bus.disp_value = '0;
        bus.disp_blank = '1;
      end
    endcase
  end

  assign bus.mult_start = (r_state == ST_LAUNCH);
  assign bus.mult_op_a  = r_op_a;
  assign bus.mult_op_b  = r_op_b;
  assign bus.busy       = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);
  assign bus.err        = (r_state == ST_ERR);
  assign bus.state_dbg  = r_state;

endmodule
